memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Sits directly downstream of the data cache and instruction cache and upstream of the RAM model.
- Arbitrates word-level requests from both caches onto the single RAM port.
- Data-cache requests have priority. A granted requester keeps the port for a contiguous burst, so that block write-back, fill, flush and hit-count sequences are never interleaved.
- Holds the grant in a registered FSM and returns per-requester wait and load signals.

Parameters:
- MAX_BURST, 4: maximum words a requester may complete under one grant while the other requester is waiting. Must be ≥ 2 so a 2-word block transfer is never split.
- CNT_W, 3: width of the burst counter. Must satisfy 2^CNT_W > MAX_BURST.

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  icache read request
- iaddr  input  32  icache word address
- iwait  output  1  icache stall; low exactly in the cycle the icache word completes
- iload  output  32  icache read data, valid when iwait=0
- dREN  input  1  dcache read request
- dWEN  input  1  dcache write request
- daddr  input  32  dcache word address
- dstore  input  32  dcache write data
- dwait  output  1  dcache stall; low exactly in the cycle the dcache word completes
- dload  output  32  dcache read data, valid when dwait=0
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data
- ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Reset (asynchronous, nRST low): state=IDLE, burst_cnt=0. Outputs: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0. A reset mid-transfer abandons that transfer; the requester re-issues it after reset.
- States:
  - IDLE: no grant.
  - DGNT: dcache owns the RAM port.
  - IGNT: icache owns the RAM port.
- IDLE transitions:
  - dreq = dREN|dWEN high: go to DGNT.
  - Else if iREN: go to IGNT.
  - Else stay in IDLE.
  - Both requesting: DGNT wins.
  - Grant takes effect the next cycle, so minimum latency from request to first completed word is 2 cycles (1 arbitration + at least 1 RAM).
- In DGNT, RAM outputs follow the dcache inputs combinationally:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN, ramREN=dREN&~dWEN. dREN and dWEN both high is illegal; write wins.
- In IGNT: ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0.
- Word completion: granted requester's request is high and ramstate==ACCESS.
  - That requester's wait drops to 0 for that cycle only.
  - Its load output equals ramload in that cycle and is 0 otherwise.
  - burst_cnt increments on completion and saturates at MAX_BURST.
- A non-granted requester always sees wait=1.
- ramstate BUSY or FREE: wait stays 1 and outputs stay driven; the RAM model completes later.
- ramstate ERROR: wait stays 1 and the access keeps being driven, so the access retries. No completion is counted.
- Grant release (evaluated at the clock edge) happens when either:
  - the owner's request is low in the current cycle, or
  - burst_cnt reaches MAX_BURST on a completion while the other requester is pending.
- On release, go to the other requester's grant state if it is pending, else to IDLE; burst_cnt clears to 0.
- If the owner stays the only requester, the grant persists indefinitely and burst_cnt stays saturated.
- The dcache 2-word sequences (write-back, fill, flush pair, hit-count store) hold dreq high across both words and therefore stay contiguous under one grant.
- Simultaneous events:
  - Release and a new request in the same cycle: the new request is honoured at that edge with no IDLE bubble.
  - Owner drops its request in the same cycle as a completion: the word is delivered, then the grant is released.
- No ramaddr alignment checks; addresses pass through unchanged.

Decomposition:
- ramstate_t (FREE/BUSY/ACCESS/ERROR) and word_t live in cpu_types_pkg.
- The arbiter FSM state enum (IDLE/DGNT/IGNT) is local to this module.
- The block uses the caches interface modport for the cache-side ports.
- No sub-module: a single FSM plus the burst counter.

Test Plan:
- Reset with both requests high: after nRST rises, iwait=dwait=1 and ramREN=ramWEN=0 for one cycle, then DGNT is granted; with ramstate=ACCESS, dwait=0 in cycle 2 and iwait stays 1.
- dcache 2-word write-back (daddr 0x100 then 0x104, dWEN high throughout) with iREN pending: ramWEN=1 on both words with no icache cycle between them; IGNT follows, iaddr appears on ramaddr.
- icache fetch 0x40, ramload=0xDEADBEEF, 3 BUSY cycles then ACCESS: iwait=0 only in the ACCESS cycle with iload=0xDEADBEEF; dload=0.
- Fairness: dcache reads continuously and iREN is held; after 4 completions, grant moves to IGNT and the icache completes one word before DGNT returns.
- ERROR injected on a dcache read: dwait stays 1, ramREN stays asserted, burst_cnt unchanged; the following ACCESS completes with dload=ramload.
- nRST pulsed mid-DGNT: all outputs return to reset values immediately; state=IDLE and burst_cnt=0 after release.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared CPU word and RAM status types
package memory_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: cache-side requests and the single RAM port seen by the arbiter
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;
  logic      iREN, iwait, dREN, dWEN, dwait, ramREN, ramWEN;
  word_t     iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: grants the RAM port to the dcache (priority) or icache,
// keeping each grant for a contiguous burst bounded by MAX_BURST under contention
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input logic              CLK,
  input logic              nRST,
  memory_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(MAX_BURST);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt, w_cnt_inc;
  logic             w_dreq, w_dgnt, w_ignt, w_dcomp, w_icomp, w_own, w_other, w_release;
  always_comb begin
    w_dreq    = bus.dREN | bus.dWEN;
    w_dgnt    = r_state == DGNT;
    w_ignt    = r_state == IGNT;
    w_dcomp   = w_dgnt && w_dreq && bus.ramstate == ACCESS;
    w_icomp   = w_ignt && bus.iREN && bus.ramstate == ACCESS;
    w_own     = w_dgnt ? w_dreq : w_ignt && bus.iREN;
    w_other   = w_dgnt ? bus.iREN : w_dreq;
    w_cnt_inc = r_cnt == CMAX ? r_cnt : r_cnt + 1'b1;
    // release once the burst quota is spent, but only if someone is waiting
    w_release = !w_own || ((w_dcomp || w_icomp) && w_cnt_inc == CMAX && w_other);
    bus.ramaddr  = w_dgnt ? bus.daddr : w_ignt ? bus.iaddr : '0;
    bus.ramstore = w_dgnt ? bus.dstore : '0;
    bus.ramWEN   = w_dgnt && bus.dWEN;
    bus.ramREN   = w_dgnt ? bus.dREN && !bus.dWEN : w_ignt && bus.iREN;
    bus.dwait    = !w_dcomp;
    bus.iwait    = !w_icomp;
    bus.dload    = w_dcomp ? bus.ramload : '0;
    bus.iload    = w_icomp ? bus.ramload : '0;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (r_state == IDLE)
      r_state <= w_dreq ? DGNT : bus.iREN ? IGNT : IDLE;
    else if (w_release) begin
      r_state <= w_dgnt ? (bus.iREN ? IGNT : IDLE) : (w_dreq ? DGNT : IDLE);
      r_cnt   <= '0;
    end else if (w_dcomp || w_icomp)
      r_cnt <= w_cnt_inc;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic checked against
// a grant/burst reference model of the arbiter
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;
  localparam int MAXB = 4;
  logic CLK = 0, nRST = 0;
  int checks = 0, errors = 0;
  memory_arbiter_if bus();
  memory_arbiter #(.MAX_BURST(MAXB), .CNT_W(3)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  always #5 CLK = ~CLK;

  task automatic zero_inputs();
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = FREE;
  endtask

  task automatic settle();
    @(posedge CLK); #1 zero_inputs();
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    zero_inputs();
    bus.dREN = 1; bus.iREN = 1; bus.daddr = 32'h10; bus.iaddr = 32'h20;
    bus.ramstate = ACCESS; bus.ramload = 32'h1234;
    @(negedge CLK);
    checks++; if (bus.dwait !== 1'b1) begin errors++; $display("FAIL rst_dwait got %b exp 1", bus.dwait); end
    checks++; if (bus.iwait !== 1'b1) begin errors++; $display("FAIL rst_iwait got %b exp 1", bus.iwait); end
    checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b00) begin errors++; $display("FAIL rst_ramen got %b exp 00", {bus.ramREN, bus.ramWEN}); end
    checks++; if (bus.ramaddr !== 32'h0) begin errors++; $display("FAIL rst_ramaddr got %h exp 0", bus.ramaddr); end
    checks++; if (bus.dload !== 32'h0) begin errors++; $display("FAIL rst_dload got %h exp 0", bus.dload); end
    @(posedge CLK); #1 nRST = 1;
    @(negedge CLK);
    checks++; if ({bus.dwait, bus.iwait, bus.ramREN, bus.ramWEN} !== 4'b1100) begin errors++; $display("FAIL rst_arb_cycle got %b exp 1100", {bus.dwait, bus.iwait, bus.ramREN, bus.ramWEN}); end
    @(negedge CLK);
    checks++; if (bus.dwait !== 1'b0) begin errors++; $display("FAIL rst_dgnt_dwait got %b exp 0", bus.dwait); end
    checks++; if (bus.iwait !== 1'b1) begin errors++; $display("FAIL rst_dgnt_iwait got %b exp 1", bus.iwait); end
    checks++; if (bus.dload !== 32'h1234) begin errors++; $display("FAIL rst_dgnt_dload got %h exp 1234", bus.dload); end
    checks++; if (bus.ramaddr !== 32'h10) begin errors++; $display("FAIL rst_dgnt_ramaddr got %h exp 10", bus.ramaddr); end
    settle();
  endtask

  task automatic test_writeback();
    bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hA1; bus.iREN = 1; bus.iaddr = 32'h40;
    bus.ramstate = ACCESS; bus.ramload = 32'h55;
    @(negedge CLK);
    checks++; if (bus.ramWEN !== 1'b0) begin errors++; $display("FAIL wb_arb_ramWEN got %b exp 0", bus.ramWEN); end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if ({bus.ramWEN, bus.dwait, bus.iwait} !== 3'b101) begin errors++; $display("FAIL wb_w0_ctl got %b exp 101", {bus.ramWEN, bus.dwait, bus.iwait}); end
    checks++; if (bus.ramaddr !== 32'h100 || bus.ramstore !== 32'hA1) begin errors++; $display("FAIL wb_w0_bus got %h/%h exp 100/a1", bus.ramaddr, bus.ramstore); end
    @(posedge CLK); #1 bus.daddr = 32'h104; bus.dstore = 32'hA2;
    @(negedge CLK);
    checks++; if ({bus.ramWEN, bus.ramREN, bus.dwait, bus.iwait} !== 4'b1001) begin errors++; $display("FAIL wb_w1_ctl got %b exp 1001", {bus.ramWEN, bus.ramREN, bus.dwait, bus.iwait}); end
    checks++; if (bus.ramaddr !== 32'h104 || bus.ramstore !== 32'hA2) begin errors++; $display("FAIL wb_w1_bus got %h/%h exp 104/a2", bus.ramaddr, bus.ramstore); end
    @(posedge CLK); #1 bus.dWEN = 0;
    @(negedge CLK);
    checks++; if ({bus.ramWEN, bus.iwait} !== 2'b01) begin errors++; $display("FAIL wb_drop got %b exp 01", {bus.ramWEN, bus.iwait}); end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if (bus.ramaddr !== 32'h40 || bus.ramREN !== 1'b1) begin errors++; $display("FAIL wb_igrant got %h/%b exp 40/1", bus.ramaddr, bus.ramREN); end
    checks++; if (bus.iwait !== 1'b0 || bus.iload !== 32'h55) begin errors++; $display("FAIL wb_iload got %b/%h exp 0/55", bus.iwait, bus.iload); end
    settle();
  endtask

  task automatic test_busy_fetch();
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramload = 32'hDEADBEEF; bus.ramstate = BUSY;
    @(posedge CLK); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checks++; if (bus.iwait !== 1'b1 || bus.iload !== 32'h0) begin errors++; $display("FAIL busy%0d got %b/%h exp 1/0", k, bus.iwait, bus.iload); end
      checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40) begin errors++; $display("FAIL busy%0d_drive got %b/%h exp 1/40", k, bus.ramREN, bus.ramaddr); end
      @(posedge CLK); #1;
    end
    bus.ramstate = ACCESS;
    @(negedge CLK);
    checks++; if (bus.iwait !== 1'b0 || bus.iload !== 32'hDEADBEEF) begin errors++; $display("FAIL busy_done got %b/%h exp 0/deadbeef", bus.iwait, bus.iload); end
    checks++; if (bus.dload !== 32'h0 || bus.dwait !== 1'b1) begin errors++; $display("FAIL busy_dside got %h/%b exp 0/1", bus.dload, bus.dwait); end
    settle();
  endtask

  task automatic test_fairness();
    bus.dREN = 1; bus.iREN = 1; bus.iaddr = 32'h80; bus.ramstate = ACCESS;
    @(posedge CLK); #1;
    for (int k = 0; k < MAXB; k++) begin
      bus.daddr = 32'h200 + 32'(4 * k); bus.ramload = 32'(k + 1);
      @(negedge CLK);
      checks++; if ({bus.dwait, bus.iwait} !== 2'b01 || bus.dload !== 32'(k + 1)) begin errors++; $display("FAIL fair_d%0d got %b/%h exp 01/%0h", k, {bus.dwait, bus.iwait}, bus.dload, k + 1); end
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    checks++; if ({bus.dwait, bus.iwait} !== 2'b10 || bus.ramaddr !== 32'h80) begin errors++; $display("FAIL fair_ignt got %b/%h exp 10/80", {bus.dwait, bus.iwait}, bus.ramaddr); end
    @(posedge CLK); #1 bus.iREN = 0;
    @(negedge CLK);
    checks++; if ({bus.dwait, bus.iwait} !== 2'b11) begin errors++; $display("FAIL fair_idrop got %b exp 11", {bus.dwait, bus.iwait}); end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if (bus.dwait !== 1'b0 || bus.ramaddr !== bus.daddr) begin errors++; $display("FAIL fair_dback got %b/%h exp 0/%h", bus.dwait, bus.ramaddr, bus.daddr); end
    settle();
  endtask

  task automatic test_error();
    bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = ERROR; bus.ramload = 32'h77;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if ({bus.dwait, bus.ramREN} !== 2'b11 || bus.dload !== 32'h0) begin errors++; $display("FAIL err_hold got %b/%h exp 11/0", {bus.dwait, bus.ramREN}, bus.dload); end
    @(posedge CLK); #1;
    checks++; if (dut.r_cnt !== 3'd0) begin errors++; $display("FAIL err_cnt got %0d exp 0", dut.r_cnt); end
    bus.ramstate = ACCESS;
    @(negedge CLK);
    checks++; if (bus.dwait !== 1'b0 || bus.dload !== 32'h77) begin errors++; $display("FAIL err_retry got %b/%h exp 0/77", bus.dwait, bus.dload); end
    @(posedge CLK); #1;
    checks++; if (dut.r_cnt !== 3'd1) begin errors++; $display("FAIL err_cnt_after got %0d exp 1", dut.r_cnt); end
    settle();
  endtask

  task automatic test_reset_mid();
    bus.dREN = 1; bus.daddr = 32'h400; bus.ramstate = ACCESS; bus.ramload = 32'h9;
    repeat (2) begin @(posedge CLK); #1; end
    @(negedge CLK);
    checks++; if (bus.dwait !== 1'b0) begin errors++; $display("FAIL rmid_pre got %b exp 0", bus.dwait); end
    #1 nRST = 0;
    #1;
    checks++; if ({bus.dwait, bus.iwait, bus.ramREN, bus.ramWEN} !== 4'b1100) begin errors++; $display("FAIL rmid_ctl got %b exp 1100", {bus.dwait, bus.iwait, bus.ramREN, bus.ramWEN}); end
    checks++; if (bus.ramaddr !== 32'h0 || bus.dload !== 32'h0) begin errors++; $display("FAIL rmid_bus got %h/%h exp 0/0", bus.ramaddr, bus.dload); end
    bus.dREN = 0;
    @(posedge CLK); #1 nRST = 1;
    @(negedge CLK);
    checks++; if (dut.r_state !== 2'd0 || dut.r_cnt !== 3'd0) begin errors++; $display("FAIL rmid_state got %0d/%0d exp 0/0", dut.r_state, dut.r_cnt); end
    settle();
  endtask

  task automatic test_random();
    int owner = 0, served = 0, dmode = 0;
    logic dq, iq, own_req, oth_req, done, leave;
    logic [31:0] e_addr, e_store, e_dload, e_iload;
    logic e_ren, e_wen;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) dmode = ($urandom_range(15) == 0) ? 3 : int'($urandom_range(2));
      if ($urandom_range(3) == 0) bus.iREN = ~bus.iREN;
      bus.dREN = dmode == 1 || dmode == 3; bus.dWEN = dmode >= 2;
      bus.daddr = $urandom; bus.iaddr = $urandom; bus.dstore = $urandom; bus.ramload = $urandom;
      bus.ramstate = $urandom_range(1) ? ACCESS : ramstate_t'($urandom_range(3));
      @(negedge CLK);
      dq = bus.dREN | bus.dWEN; iq = bus.iREN;
      own_req = owner == 1 ? dq : owner == 2 ? iq : 1'b0;
      oth_req = owner == 1 ? iq : dq;
      done = own_req && bus.ramstate == ACCESS;
      e_addr  = owner == 1 ? bus.daddr : owner == 2 ? bus.iaddr : 32'h0;
      e_store = owner == 1 ? bus.dstore : 32'h0;
      e_wen   = owner == 1 && bus.dWEN;
      e_ren   = owner == 1 ? bus.dREN && !bus.dWEN : owner == 2 && iq;
      e_dload = (done && owner == 1) ? bus.ramload : 32'h0;
      e_iload = (done && owner == 2) ? bus.ramload : 32'h0;
      checks++; if (bus.ramaddr !== e_addr) begin errors++; $display("FAIL rnd%0d ramaddr got %h exp %h", n, bus.ramaddr, e_addr); end
      checks++; if (bus.ramstore !== e_store) begin errors++; $display("FAIL rnd%0d ramstore got %h exp %h", n, bus.ramstore, e_store); end
      checks++; if ({bus.ramREN, bus.ramWEN} !== {e_ren, e_wen}) begin errors++; $display("FAIL rnd%0d ramen got %b exp %b", n, {bus.ramREN, bus.ramWEN}, {e_ren, e_wen}); end
      checks++; if ({bus.dwait, bus.iwait} !== {!(done && owner == 1), !(done && owner == 2)}) begin errors++; $display("FAIL rnd%0d waits got %b owner %0d done %b", n, {bus.dwait, bus.iwait}, owner, done); end
      checks++; if (bus.dload !== e_dload || bus.iload !== e_iload) begin errors++; $display("FAIL rnd%0d loads got %h/%h exp %h/%h", n, bus.dload, bus.iload, e_dload, e_iload); end
      if (done && served < MAXB) served++;
      leave = !own_req || (done && served == MAXB && oth_req);
      if (owner == 0) owner = dq ? 1 : iq ? 2 : 0;
      else if (leave) begin
        owner = !oth_req ? 0 : owner == 1 ? 2 : 1;
        served = 0;
      end
      @(posedge CLK); #1;
    end
    settle();
  endtask

  initial begin
    zero_inputs();
    test_reset();
    test_writeback();
    test_busy_fetch();
    test_fairness();
    test_error();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
